// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared constants for the clock_divider block
package clock_divider_pkg;

    localparam int CNT_W = 4;

    // Division ratio of each output, LSB output first
    localparam int DIV_RATIO [CNT_W] = '{2, 4, 8, 16};

endpackage

// File: rtl/clock_divider_if.sv
// rtl/clock_divider_if.sv - bundle of the four divided clock outputs
interface clock_divider_if;

    logic divideby2;
    logic divideby4;
    logic divideby8;
    logic divideby16;

    modport master (
        output divideby2,
        output divideby4,
        output divideby8,
        output divideby16
    );

    modport slave (
        input divideby2,
        input divideby4,
        input divideby8,
        input divideby16
    );

endinterface

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - free-running /2 /4 /8 /16 divider from one 4-bit counter
// Optional simulation assertions: define CLOCK_DIVIDER_ASSERT_EN
module clock_divider
    import clock_divider_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    clock_divider_if.master div
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Every output is a flop bit, so the outputs are glitch-free and phase-aligned
    assign div.divideby2  = cnt[0];
    assign div.divideby4  = cnt[1];
    assign div.divideby8  = cnt[2];
    assign div.divideby16 = cnt[3];

`ifdef CLOCK_DIVIDER_ASSERT_EN
    // run_q marks edges whose previous sample was taken outside reset
    logic run_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    a_div2_toggles: assert property (
        @(posedge clk) disable iff (!rst)
        run_q |-> (cnt[0] != $past(cnt[0]))
    );

    for (genvar k = 1; k < CNT_W; k++) begin : g_carry_chk
        a_toggle_on_carry: assert property (
            @(posedge clk) disable iff (!rst)
            run_q |-> ((cnt[k] != $past(cnt[k])) == (&$past(cnt[k-1:0])))
        );
    end

    a_zero_in_reset: assert property (
        @(posedge clk) !rst |-> (cnt == '0)
    );
`else
`endif

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - self-checking bench for clock_divider
module tb_clock_divider;
    import clock_divider_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   edges;

    clock_divider_if bus ();

    clock_divider dut (
        .clk (clk),
        .rst (rst),
        .div (bus)
    );

    wire [3:0] obs = {bus.divideby16, bus.divideby8, bus.divideby4, bus.divideby2};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output k is high during the second half of each DIV_RATIO[k]-edge window
    function automatic logic [3:0] model(input int n);
        logic [3:0] e;
        for (int k = 0; k < CNT_W; k++) begin
            e[k] = (n % DIV_RATIO[k]) >= (DIV_RATIO[k] / 2);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    always @(negedge clk) begin
        check("model_compare", int'(obs), int'(model(edges)));
    end

    int lit_seq [17] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};

    initial begin
        time rise0 [4];
        time rise1 [4];
        time fall0 [4];
        logic [3:0] prev;
        bit found;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;

        #25 check("reset_hold_25ns", int'(obs), 0);
        #20 check("reset_hold_45ns", int'(obs), 0);
        #10 rst = 1'b1;
        check("after_release", int'(obs), 0);

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1 check($sformatf("seq_edge_%0d", i + 1), int'(obs), lit_seq[i]);
        end

        for (int k = 0; k < 4; k++) begin
            rise0[k] = 0; rise1[k] = 0; fall0[k] = 0;
        end
        prev = obs;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (!prev[k] && obs[k]) begin
                    if (rise0[k] == 0)      rise0[k] = $time;
                    else if (rise1[k] == 0) rise1[k] = $time;
                end
                if (prev[k] && !obs[k] && rise0[k] != 0 && fall0[k] == 0)
                    fall0[k] = $time;
            end
            prev = obs;
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("period_div%0d", DIV_RATIO[k]),
                  (rise1[k] == 0) ? -1 : int'(rise1[k] - rise0[k]), 20 * DIV_RATIO[k]);
            check($sformatf("high_div%0d", DIV_RATIO[k]),
                  (fall0[k] == 0) ? -1 : int'(fall0[k] - rise0[k]), 10 * DIV_RATIO[k]);
        end

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1 if (obs == 4'd9) found = 1'b1;
        end
        check("reach_count_9", int'(found), 1);
        #4 rst = 1'b0;
        #1 check("async_reset_immediate", int'(obs), 0);
        @(posedge clk);
        #1 check("held_reset_edge", int'(obs), 0);
        #4 rst = 1'b1;
        @(posedge clk);
        #1 check("restart_count_1", int'(obs), 1);
        @(posedge clk);
        #1 check("restart_count_2", int'(obs), 2);

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
